// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix cascade receiver.
package matrix_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned ADDR_W   = 4;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned DATA_W   = 8;

  localparam logic [3:0] REG_NOOP      = 4'h0;
  localparam logic [3:0] REG_DIGIT1    = 4'h1;
  localparam logic [3:0] REG_DIGIT8    = 4'h8;
  localparam logic [3:0] REG_DECODE    = 4'h9;
  localparam logic [3:0] REG_INTENSITY = 4'hA;
  localparam logic [3:0] REG_SCANLIM   = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN  = 4'hC;
  localparam logic [3:0] REG_DISPTEST  = 4'hF;

  typedef enum logic [0:0] {IDLE, SHIFT} state_t;

endpackage

// File: rtl/matrix_rx_shifter.sv
// Frame deserialiser: cs edge detect, shift register, bit counter and hold register.
// A frame is accepted only if exactly FRM_W bits were shifted while cs was low.
module matrix_rx_shifter
  import matrix_pkg::*;
#(
  parameter int unsigned FRM_W = 64
) (
  input  logic             clk_9m,
  input  logic             rst,
  input  logic             cs,
  input  logic             sin,
  output logic [FRM_W-1:0] hold,
  output logic             commit_pend,
  output logic             len_err
);

  localparam int unsigned     CNT_W    = $clog2(FRM_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRM_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRM_W + 1);

  state_t           state_q, state_d;
  logic             frame_end;
  logic [FRM_W-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;

  // State register; SHIFT means cs was low on the previous edge.
  always_ff @(posedge clk_9m or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state follows cs; leaving SHIFT marks the end of a frame.
  always_comb begin
    state_d   = state_q;
    frame_end = 1'b0;
    unique case (state_q)
      IDLE:  if (!cs) state_d = SHIFT;
      SHIFT: if (cs) begin
        state_d   = IDLE;
        frame_end = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift, count (saturating) and latch a complete frame into hold.
  always_ff @(posedge clk_9m or posedge rst) begin
    if (rst) begin
      sr_q        <= '0;
      cnt_q       <= '0;
      hold        <= '0;
      commit_pend <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      len_err     <= 1'b0;
      if (!cs) begin
        sr_q <= {sr_q[FRM_W-2:0], sin};
        if (cnt_q != CNT_SAT) cnt_q <= cnt_q + 1'b1;
      end else if (frame_end) begin
        cnt_q <= '0;
        if (cnt_q == CNT_FULL) begin
          hold        <= sr_q;
          commit_pend <= 1'b1;
        end else begin
          len_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_rx.sv
// Receive end of the matrix cascade link: shadows every device's digit and config registers.
// Optional feature: define MATRIX_RX_DISPTEST_EN to honour the display-test register (addr 0xF).
module matrix_rx
  import matrix_pkg::*;
#(
  parameter int unsigned N_DEV = 4
) (
  input  logic               clk_9m,
  input  logic               rst,
  input  logic               cs,
  input  logic               sin,
  output logic [8*N_DEV-1:0] rows [8],
  output logic [4*N_DEV-1:0] intensity,
  output logic [3*N_DEV-1:0] scan_limit,
  output logic [8*N_DEV-1:0] decode_mode,
  output logic [N_DEV-1:0]   shutdown_n,
  output logic               frame_valid,
  output logic               frame_err
);

  localparam int unsigned FRM_W = WORD_W * N_DEV;

  logic [FRM_W-1:0]   hold;
  logic               commit_pend;
  logic               len_err;
  logic [3:0]         addr    [N_DEV];
  logic [7:0]         data    [N_DEV];
  logic [2:0]         row_idx [N_DEV];
  logic [8*N_DEV-1:0] rows_q  [8];
  logic               unused_nib;
`ifdef MATRIX_RX_DISPTEST_EN
  logic [N_DEV-1:0]   disp_test_q;
`endif

  matrix_rx_shifter #(
    .FRM_W (FRM_W)
  ) u_shifter (
    .clk_9m      (clk_9m),
    .rst         (rst),
    .cs          (cs),
    .sin         (sin),
    .hold        (hold),
    .commit_pend (commit_pend),
    .len_err     (len_err)
  );

  // Split the held frame into per-device address/data fields; the top nibble is don't-care.
  always_comb begin
    unused_nib = 1'b0;
    for (int k = 0; k < N_DEV; k++) begin
      addr[k]    = hold[WORD_W*k + ADDR_LSB +: ADDR_W];
      data[k]    = hold[WORD_W*k + DATA_LSB +: DATA_W];
      row_idx[k] = 3'(addr[k] - REG_DIGIT1);
      unused_nib = unused_nib ^ (^hold[WORD_W*k + 12 +: 4]);
    end
  end

  // Register file: all devices are updated in parallel on the commit cycle.
  always_ff @(posedge clk_9m or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 8; d++) rows_q[d] <= '0;
      intensity   <= '0;
      scan_limit  <= '0;
      decode_mode <= '0;
      shutdown_n  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
`ifdef MATRIX_RX_DISPTEST_EN
      disp_test_q <= '0;
`endif
    end else begin
      frame_valid <= commit_pend;
      frame_err   <= len_err;
      if (commit_pend) begin
        for (int k = 0; k < N_DEV; k++) begin
          case (addr[k])
            REG_DECODE:    decode_mode[8*k +: 8] <= data[k];
            REG_INTENSITY: intensity[4*k +: 4]   <= data[k][3:0];
            REG_SCANLIM:   scan_limit[3*k +: 3]  <= data[k][2:0];
            REG_SHUTDOWN:  shutdown_n[k]         <= data[k][0];
`ifdef MATRIX_RX_DISPTEST_EN
            REG_DISPTEST:  disp_test_q[k]        <= data[k][0];
`endif
            default: begin
              if (addr[k] >= REG_DIGIT1 && addr[k] <= REG_DIGIT8)
                rows_q[row_idx[k]][8*k +: 8] <= data[k];
            end
          endcase
        end
      end
    end
  end

  // Row view: display test forces a device's bytes to all-on without touching stored digits.
  always_comb begin
    for (int d = 0; d < 8; d++) begin
      rows[d] = rows_q[d];
`ifdef MATRIX_RX_DISPTEST_EN
      for (int k = 0; k < N_DEV; k++) begin
        if (disp_test_q[k]) rows[d][8*k +: 8] = 8'hFF;
      end
`endif
    end
  end

endmodule

// File: tb/tb_matrix_rx.sv
// Self-checking bench for matrix_rx: frame-level behavioural model plus literal spot checks.
module tb_matrix_rx;

  localparam int unsigned N_DEV = 4;

  logic               clk_9m = 1'b0;
  logic               rst    = 1'b1;
  logic               cs     = 1'b1;
  logic               sin    = 1'b0;
  logic [8*N_DEV-1:0] rows [8];
  logic [4*N_DEV-1:0] intensity;
  logic [3*N_DEV-1:0] scan_limit;
  logic [8*N_DEV-1:0] decode_mode;
  logic [N_DEV-1:0]   shutdown_n;
  logic               frame_valid;
  logic               frame_err;

  matrix_rx #(
    .N_DEV (N_DEV)
  ) dut (
    .clk_9m      (clk_9m),
    .rst         (rst),
    .cs          (cs),
    .sin         (sin),
    .rows        (rows),
    .intensity   (intensity),
    .scan_limit  (scan_limit),
    .decode_mode (decode_mode),
    .shutdown_n  (shutdown_n),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk_9m = ~clk_9m;

  int n_tests = 0;
  int n_fail  = 0;
  int dut_valid_cnt = 0;
  int dut_err_cnt   = 0;
  int good_sent = 0;
  int bad_sent  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model (per-device register view) ----------------
  logic [7:0]  m_dig  [N_DEV][8];
  logic [3:0]  m_int  [N_DEV];
  logic [2:0]  m_scan [N_DEV];
  logic [7:0]  m_dec  [N_DEV];
  logic        m_shd  [N_DEV];
  logic        m_dt   [N_DEV];
  logic        m_valid = 1'b0;
  logic        m_err   = 1'b0;
  bit          bits_q [$];
  bit          prev_cs = 1'b1;
  bit          pend_commit = 1'b0;
  bit          pend_err = 1'b0;
  logic [15:0] pend_word [N_DEV];

  task automatic model_reset();
    for (int k = 0; k < N_DEV; k++) begin
      for (int r = 0; r < 8; r++) m_dig[k][r] = 8'h00;
      m_int[k] = 0; m_scan[k] = 0; m_dec[k] = 0; m_shd[k] = 0; m_dt[k] = 0;
    end
    m_valid = 0; m_err = 0; pend_commit = 0; pend_err = 0; prev_cs = 1; bits_q.delete();
  endtask

  task automatic model_apply();
    for (int k = 0; k < N_DEV; k++) begin
      int unsigned a = pend_word[k][11:8];
      logic [7:0]  v = pend_word[k][7:0];
      if (a >= 1 && a <= 8) m_dig[k][a-1] = v;
      else if (a == 9)  m_dec[k] = v;
      else if (a == 10) m_int[k] = v[3:0];
      else if (a == 11) m_scan[k] = v[2:0];
      else if (a == 12) m_shd[k] = v[0];
`ifdef MATRIX_RX_DISPTEST_EN
      else if (a == 15) m_dt[k] = v[0];
`endif
    end
  endtask

  // Model advances once per clock edge; a frame is judged on the edge where cs is first seen high.
  initial begin
    model_reset();
    forever begin
      @(posedge clk_9m or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        m_valid = 0;
        m_err   = 0;
        if (pend_commit) begin
          model_apply();
          m_valid = 1;
          pend_commit = 0;
        end
        if (pend_err) begin
          m_err = 1;
          pend_err = 0;
        end
        if (!cs) begin
          bits_q.push_back(sin);
        end else if (!prev_cs) begin
          if (bits_q.size() == 16 * N_DEV) begin
            // First-sent word belongs to the last device.
            for (int k = 0; k < N_DEV; k++)
              for (int j = 0; j < 16; j++)
                pend_word[k][15-j] = bits_q[16*(N_DEV-1-k) + j];
            pend_commit = 1;
          end else begin
            pend_err = 1;
          end
          bits_q.delete();
        end
        prev_cs = cs;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk_9m);
      if (!rst) begin
        logic [8*N_DEV-1:0] er;
        logic [4*N_DEV-1:0] ei;
        logic [3*N_DEV-1:0] es;
        logic [8*N_DEV-1:0] ed;
        logic [N_DEV-1:0]   eh;
        if (frame_valid === 1'b1) dut_valid_cnt++;
        if (frame_err === 1'b1)   dut_err_cnt++;
        for (int k = 0; k < N_DEV; k++) begin
          ei[4*k +: 4] = m_int[k];
          es[3*k +: 3] = m_scan[k];
          ed[8*k +: 8] = m_dec[k];
          eh[k]        = m_shd[k];
        end
        for (int d = 0; d < 8; d++) begin
          for (int k = 0; k < N_DEV; k++) er[8*k +: 8] = m_dt[k] ? 8'hFF : m_dig[k][d];
          check($sformatf("rows[%0d]", d), rows[d], er);
        end
        check("intensity", intensity, ei);
        check("scan_limit", scan_limit, es);
        check("decode_mode", decode_mode, ed);
        check("shutdown_n", shutdown_n, eh);
        check("frame_valid", frame_valid, m_valid);
        check("frame_err", frame_err, m_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_bits(input logic [127:0] v, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_9m);
      cs  = 1'b0;
      sin = v[n-1-i];
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge clk_9m);
      cs  = 1'b1;
      sin = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [63:0] f, input int gap);
    send_bits({64'd0, f}, 64, gap);
    good_sent++;
  endtask

  task automatic send_bad(input int n, input int gap);
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    send_bits(v, n, gap);
    bad_sent++;
  endtask

  initial begin
    int vbase, ebase;
    logic [15:0] w;
    logic [7:0]  b7;

    repeat (3) @(negedge clk_9m);
    #1 rst = 1'b0;
    @(negedge clk_9m);
    check("reset intensity", intensity, 16'h0);
    check("reset shutdown_n", shutdown_n, 4'h0);
    check("reset rows[3]", rows[3], 32'h0);

    // Init sequence.
    vbase = dut_valid_cnt;
    send_frame({4{16'h0900}}, 1);
    send_frame({4{16'h0A04}}, 1);
    send_frame({4{16'h0B07}}, 1);
    send_frame({4{16'h0C01}}, 3);
    check("init decode_mode", decode_mode, 32'h0);
    check("init intensity", intensity, 16'h4444);
    check("init scan_limit", scan_limit, 12'o7777);
    check("init shutdown_n", shutdown_n, 4'hF);
    check("init valid pulses", dut_valid_cnt - vbase, 4);

    // Eight row frames, back to back with 1-cycle gaps.
    vbase = dut_valid_cnt;
    ebase = dut_err_cnt;
    for (int n = 1; n <= 8; n++) begin
      w = 16'h005A;
      w[11:8] = 4'(n);
      send_frame({4{w}}, (n == 8) ? 3 : 1);
    end
    for (int d = 0; d < 8; d++) check($sformatf("row frame rows[%0d]", d), rows[d], 32'h5A5A5A5A);
    check("row valid pulses", dut_valid_cnt - vbase, 8);
    check("row err pulses", dut_err_cnt - ebase, 0);

    // Mixed frame: first word targets the last device.
    send_frame({16'h08C3, 16'h0000, 16'h0000, 16'h0111}, 3);
    check("mixed rows[7]", rows[7], 32'hC35A5A5A);
    check("mixed rows[0]", rows[0], 32'h5A5A5A11);

    // Short and long frames are discarded.
    vbase = dut_valid_cnt;
    ebase = dut_err_cnt;
    send_bad(40, 2);
    send_bad(70, 3);
    check("bad err pulses", dut_err_cnt - ebase, 2);
    check("bad valid pulses", dut_valid_cnt - vbase, 0);
    check("bad rows[7]", rows[7], 32'hC35A5A5A);

    // Display-test register.
    send_frame({16'h0F01, 16'h0000, 16'h0000, 16'h0000}, 3);
`ifdef MATRIX_RX_DISPTEST_EN
    b7 = 8'hFF;
`else
    b7 = 8'hC3;
`endif
    check("disptest on rows[7]", rows[7][31:24], b7);
    check("disptest on rows[2]", rows[2][31:24], (b7 == 8'hFF) ? 8'hFF : 8'h5A);
    send_frame({16'h0F00, 16'h0000, 16'h0000, 16'h0000}, 3);
    check("disptest off rows[7]", rows[7][31:24], 8'hC3);

    // Randomised frames, mostly well-formed.
    for (int i = 0; i < 40; i++) begin
      logic [63:0] f;
      int gap;
      gap = $urandom_range(1, 3);
      if ($urandom_range(0, 9) < 8) begin
        for (int k = 0; k < N_DEV; k++) f[16*k +: 16] = 16'($urandom);
        send_frame(f, gap);
      end else begin
        int n;
        n = $urandom_range(1, 100);
        if (n == 64) n = 65;
        send_bad(n, gap);
      end
    end
    repeat (3) @(negedge clk_9m);

    // Reset in the middle of a frame, then a clean frame.
    send_bits({$urandom, $urandom, $urandom, $urandom}, 30, 0);
    @(negedge clk_9m);
    #1 rst = 1'b1;
    cs = 1'b1;
    repeat (2) @(negedge clk_9m);
    #1 rst = 1'b0;
    @(negedge clk_9m);
    check("post-reset intensity", intensity, 16'h0);
    send_frame({4{16'h0A0F}}, 3);
    check("after reset intensity", intensity, 16'hFFFF);
    check("after reset rows[0]", rows[0], 32'h0);

    check("total valid pulses", dut_valid_cnt, good_sent);
    check("total err pulses", dut_err_cnt, bad_sent);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
